// File: rtl/tstate_sequencer.sv
// ============================================================================
// Module   : tstate_sequencer
// Brief    : CPU T-state sequencer with end-of-instruction shortening, wait
//            states, wait timeout and halt/single-step at instruction
//            boundaries. State updates occur on the falling edge of clk.
//            Optional macro TSTATE_ICOUNT_EN enables the retired-instruction
//            counter; without it icount is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tstate_sequencer #(
   parameter int FETCH_T      = 2,
   parameter int WAIT_TIMEOUT = 15,
   parameter int ICW          = 16
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           end_instr,
   input  logic           wait_req,
   input  logic           halt_req,
   input  logic           step,
   output logic [2:0]     T,
   output logic           fetch,
   output logic           instr_done,
   output logic           halted,
   output logic           timeout,
   output logic [ICW-1:0] icount
);

   typedef enum logic [1:0] {
      S_RUN    = 2'd0,
      S_HALTED = 2'd1,
      S_STEP   = 2'd2
   } state_t;

   localparam logic [7:0] c_wait_last = 8'(WAIT_TIMEOUT - 1);
   localparam logic [3:0] c_fetch_t   = 4'(FETCH_T);

   state_t     r_state;
   logic [2:0] r_t;
   logic [7:0] r_wait_cnt;
   logic       r_instr_done;
   logic       r_timeout;

   state_t     w_state_nxt;
   logic [2:0] w_t_nxt;
   logic [7:0] w_wait_nxt;
   logic       w_done;
   logic       w_to;
   logic       w_bound;

   always_ff @(negedge clk) begin
      if (reset) begin
         r_state      <= S_RUN;
         r_t          <= 3'd0;
         r_wait_cnt   <= 8'd0;
         r_instr_done <= 1'b0;
         r_timeout    <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_t          <= w_t_nxt;
         r_wait_cnt   <= w_wait_nxt;
         r_instr_done <= w_done;
         r_timeout    <= w_to;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_t_nxt     = r_t;
      w_wait_nxt  = 8'd0;
      w_done      = 1'b0;
      w_to        = 1'b0;
      w_bound     = 1'b0;
      case (r_state)
         S_HALTED: begin
            // Leaving HALTED treats the parked cycle as T0 of the next instruction
            w_t_nxt = 3'd0;
            if (step) begin
               w_state_nxt = S_STEP;
               w_t_nxt     = 3'd1;
            end else if (!halt_req) begin
               w_state_nxt = S_RUN;
               w_t_nxt     = 3'd1;
            end
         end
         default: begin
            if (wait_req && (r_wait_cnt == c_wait_last)) begin
               w_t_nxt = 3'd0;
               w_to    = 1'b1;
               w_bound = 1'b1;
            end else if (wait_req) begin
               w_wait_nxt = r_wait_cnt + 8'd1;
            end else if (end_instr && ({1'b0, r_t} >= c_fetch_t)) begin
               w_t_nxt = 3'd0;
               w_done  = 1'b1;
               w_bound = 1'b1;
            end else if (r_t == 3'd7) begin
               w_t_nxt = 3'd0;
               w_done  = 1'b1;
               w_bound = 1'b1;
            end else begin
               w_t_nxt = r_t + 3'd1;
            end
            if (w_bound) begin
               w_state_nxt = ((r_state == S_STEP) || halt_req) ? S_HALTED : S_RUN;
            end
         end
      endcase
   end

`ifdef TSTATE_ICOUNT_EN
   logic [ICW-1:0] r_icount;

   always_ff @(negedge clk) begin
      if (reset) begin
         r_icount <= '0;
      end else if (w_done) begin
         r_icount <= r_icount + 1'b1;
      end
   end

   assign icount = r_icount;
`else
   assign icount = '0;
`endif

   assign T          = r_t;
   assign halted     = (r_state == S_HALTED);
   assign fetch      = ({1'b0, r_t} < c_fetch_t) && !halted;
   assign instr_done = r_instr_done;
   assign timeout    = r_timeout;

endmodule

`default_nettype wire

// File: tb/tb_tstate_sequencer.sv
// ============================================================================
// Module   : tb_tstate_sequencer
// Brief    : Vector-table bench for tstate_sequencer; expected records are
//            queued when driven and popped after each falling edge.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_tstate_sequencer;

   localparam int ICW = 16;

   logic           clk = 1'b0;
   logic           reset, end_instr, wait_req, halt_req, step;
   logic [2:0]     T;
   logic           fetch, instr_done, halted, timeout;
   logic [ICW-1:0] icount;

   int tests  = 0;
   int errors = 0;

   typedef struct {
      logic       rst, e, w, h, s;
      logic [2:0] t;
      logic       d, hl, to;
   } vec_t;

   vec_t vq[$];
   vec_t sb[$];
   logic [ICW-1:0] exp_icount = '0;

   tstate_sequencer #(.FETCH_T(2), .WAIT_TIMEOUT(15), .ICW(ICW)) dut (
      .clk       (clk),
      .reset     (reset),
      .end_instr (end_instr),
      .wait_req  (wait_req),
      .halt_req  (halt_req),
      .step      (step),
      .T         (T),
      .fetch     (fetch),
      .instr_done(instr_done),
      .halted    (halted),
      .timeout   (timeout),
      .icount    (icount)
   );

   always #5 clk = ~clk;

   task automatic add(input logic rst, e, w, h, s, input int t, input logic d, hl, to);
      vec_t v;
      v.rst = rst; v.e = e; v.w = w; v.h = h; v.s = s;
      v.t = 3'(t); v.d = d; v.hl = hl; v.to = to;
      vq.push_back(v);
   endtask

   task automatic check(input int idx, input vec_t x);
      logic exp_fetch;
      exp_fetch = (x.t < 3'd2) && !x.hl;
      if (x.rst) exp_icount = '0;
`ifdef TSTATE_ICOUNT_EN
      else if (x.d) exp_icount = exp_icount + 1'b1;
`endif
      tests++;
      if (T !== x.t || instr_done !== x.d || halted !== x.hl || timeout !== x.to ||
          fetch !== exp_fetch || icount !== exp_icount) begin
         errors++;
         $display("FAIL vec%0d: got T=%0d done=%b halted=%b timeout=%b fetch=%b icount=%0d, expected T=%0d done=%b halted=%b timeout=%b fetch=%b icount=%0d",
                  idx, T, instr_done, halted, timeout, fetch, icount,
                  x.t, x.d, x.hl, x.to, exp_fetch, exp_icount);
      end
   endtask

   initial begin
      reset = 1'b1; end_instr = 1'b0; wait_req = 1'b0; halt_req = 1'b0; step = 1'b0;

      // Reset, then free-run T1..7,0,1
      add(1,0,0,0,0, 0,0,0,0);
      for (int i = 1; i <= 7; i++) add(0,0,0,0,0, i,0,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 1,0,0,0);
      // end_instr ignored in fetch, honoured at T=3 and at T=FETCH_T
      add(0,1,0,0,0, 2,0,0,0);
      add(0,0,0,0,0, 3,0,0,0);
      add(0,1,0,0,0, 0,1,0,0);
      add(0,0,0,0,0, 1,0,0,0);
      add(0,1,0,0,0, 2,0,0,0);
      add(0,1,0,0,0, 0,1,0,0);
      for (int i = 1; i <= 4; i++) add(0,0,0,0,0, i,0,0,0);
      // Short wait at T=4, then wait at T=7 delays the wrap
      for (int i = 0; i < 3; i++) add(0,0,1,0,0, 4,0,0,0);
      for (int i = 5; i <= 7; i++) add(0,0,0,0,0, i,0,0,0);
      for (int i = 0; i < 2; i++) add(0,0,1,0,0, 7,0,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      // Timeout on the 15th wait edge at T=2
      add(0,0,0,0,0, 1,0,0,0);
      add(0,0,0,0,0, 2,0,0,0);
      for (int i = 0; i < 14; i++) add(0,0,1,0,0, 2,0,0,0);
      add(0,0,1,0,0, 0,0,0,1);
      add(0,0,0,0,0, 1,0,0,0);
      // Wait counter clears on a gap: 10 + 10 wait edges never time out
      for (int i = 0; i < 10; i++) add(0,0,1,0,0, 1,0,0,0);
      add(0,0,0,0,0, 2,0,0,0);
      for (int i = 0; i < 10; i++) add(0,0,1,0,0, 2,0,0,0);
      add(0,0,0,0,0, 3,0,0,0);
      // Halt at next boundary, park, ignore wait/end while halted
      for (int i = 4; i <= 7; i++) add(0,0,0,1,0, i,0,0,0);
      add(0,0,0,1,0, 0,1,1,0);
      for (int i = 0; i < 5; i++) add(0,0,0,1,0, 0,0,1,0);
      add(0,1,1,1,0, 0,0,1,0);
      // Single step with halt held
      add(0,0,0,1,1, 1,0,0,0);
      for (int i = 2; i <= 7; i++) add(0,0,0,1,0, i,0,0,0);
      add(0,0,0,1,0, 0,1,1,0);
      // Step beats resume; STEP alone re-halts at the boundary
      add(0,0,0,0,1, 1,0,0,0);
      for (int i = 2; i <= 7; i++) add(0,0,0,0,0, i,0,0,0);
      add(0,0,0,0,0, 0,1,1,0);
      add(0,0,0,0,0, 1,0,0,0);
      // Step ignored in RUN; halt withdrawn before boundary cancels
      add(0,0,0,1,1, 2,0,0,0);
      for (int i = 3; i <= 7; i++) add(0,0,0,0,0, i,0,0,0);
      add(0,0,0,0,0, 0,1,0,0);
      // Timeout boundary with halt_req parks the sequencer
      add(0,0,0,0,0, 1,0,0,0);
      for (int i = 0; i < 14; i++) add(0,0,1,1,0, 1,0,0,0);
      add(0,0,1,1,0, 0,0,1,1);
      add(0,0,0,0,0, 1,0,0,0);
      // Reset mid-wait at T=6, then three full instructions
      for (int i = 2; i <= 6; i++) add(0,0,0,0,0, i,0,0,0);
      for (int i = 0; i < 2; i++) add(0,0,1,0,0, 6,0,0,0);
      add(1,0,1,0,0, 0,0,0,0);
      for (int k = 0; k < 3; k++) begin
         for (int i = 1; i <= 7; i++) add(0,0,0,0,0, i,0,0,0);
         add(0,0,0,0,0, 0,1,0,0);
      end
      add(0,0,0,0,0, 1,0,0,0);

      for (int i = 0; i < vq.size(); i++) begin
         @(posedge clk);
         reset = vq[i].rst; end_instr = vq[i].e; wait_req = vq[i].w;
         halt_req = vq[i].h; step = vq[i].s;
         sb.push_back(vq[i]);
         @(negedge clk);
         #1;
         check(i, sb.pop_front());
      end

      tests++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard: got %0d leftover entries, expected 0", sb.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests, errors);
      $finish;
   end

endmodule

`default_nettype wire
